// File: rtl/lrn_square_sum_if.sv
`default_nettype none
// ============================================================================
// Module      : lrn_square_sum_if
// Description : Word stream into the LRN window stage and its sum/centre outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface lrn_square_sum_if #(
    parameter int OP_WIDTH   = 16,
    parameter int NUM_PE     = 4,
    parameter int DATA_WIDTH = OP_WIDTH * NUM_PE
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  last;
    logic [DATA_WIDTH-1:0] square_sum;
    logic [DATA_WIDTH-1:0] lrn_center;
    logic                  out_valid;

    modport master (
        output enable, data_in, last,
        input  square_sum, lrn_center, out_valid
    );

    modport slave (
        input  enable, data_in, last,
        output square_sum, lrn_center, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/lrn_square_sum.sv
`default_nettype none
// ============================================================================
// Module      : lrn_square_sum
// Description : Per-lane sum of squares over a +/-RADIUS channel window that is
//               confined to the current channel group, paired with the centre word.
// Revision    : 1.0 - initial release
// ============================================================================
module lrn_square_sum #(
    parameter int OP_WIDTH   = 16,
    parameter int NUM_PE     = 4,
    parameter int RADIUS     = 2,
    parameter int SQ_SHIFT   = 8,
    parameter int DATA_WIDTH = OP_WIDTH * NUM_PE
) (
    input  wire               clk,
    input  wire               reset,
    lrn_square_sum_if.slave   bus
);
    localparam int SQ_W   = 2 * OP_WIDTH;
    localparam int NTERM  = 2 * RADIUS + 1;
    localparam int ACC_W  = SQ_W + $clog2(NTERM);

    localparam logic [ACC_W-1:0] c_SAT_MAX = ACC_W'((2 ** (OP_WIDTH - 1)) - 1);

    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_PENDING = 2'd1;
    localparam logic [1:0] c_ST_FLUSH   = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [SQ_W-1:0]       r_prev_sq [NUM_PE];
    logic [SQ_W-1:0]       r_cur_sq  [NUM_PE];

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_center;
    logic [SQ_W-1:0]       r_s1_sq   [3*NUM_PE];

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_square_sum;
    logic [DATA_WIDTH-1:0] r_lrn_center;

    logic [SQ_W-1:0]       w_in_sq   [NUM_PE];
    logic [ACC_W-1:0]      w_acc     [NUM_PE];
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_emit;
    logic                  w_next_live;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_lane_sq
            logic signed [OP_WIDTH-1:0] w_x;
            logic signed [SQ_W-1:0]     w_xe;
            logic signed [SQ_W-1:0]     w_prod;
            assign w_x         = bus.data_in[gi*OP_WIDTH +: OP_WIDTH];
            assign w_xe        = {{OP_WIDTH{w_x[OP_WIDTH-1]}}, w_x};
            assign w_prod      = w_xe * w_xe;
            assign w_in_sq[gi] = w_prod >>> SQ_SHIFT;
        end
    endgenerate

    // The centre is emitted once its successor is known: either the next word
    // of the same group arrives, or the group has ended (FLUSH).
    assign w_next_live = (r_state == c_ST_PENDING) && bus.enable;
    assign w_emit      = w_next_live || (r_state == c_ST_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
            r_cur   <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                r_prev_sq[i] <= '0;
                r_cur_sq[i]  <= '0;
            end
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (bus.enable) begin
                        r_cur <= bus.data_in;
                        for (int i = 0; i < NUM_PE; i++) begin
                            r_prev_sq[i] <= '0;
                            r_cur_sq[i]  <= w_in_sq[i];
                        end
                        r_state <= bus.last ? c_ST_FLUSH : c_ST_PENDING;
                    end
                end
                c_ST_PENDING: begin
                    if (bus.enable) begin
                        r_cur <= bus.data_in;
                        for (int i = 0; i < NUM_PE; i++) begin
                            r_prev_sq[i] <= r_cur_sq[i];
                            r_cur_sq[i]  <= w_in_sq[i];
                        end
                        r_state <= bus.last ? c_ST_FLUSH : c_ST_PENDING;
                    end
                end
                c_ST_FLUSH: begin
                    for (int i = 0; i < NUM_PE; i++) begin
                        r_prev_sq[i] <= '0;
                    end
                    if (bus.enable) begin
                        r_cur <= bus.data_in;
                        for (int i = 0; i < NUM_PE; i++) begin
                            r_cur_sq[i] <= w_in_sq[i];
                        end
                        r_state <= bus.last ? c_ST_FLUSH : c_ST_PENDING;
                    end else begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

    // Stage 1: capture prev|cur|next squares as one flat channel strip.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_center <= '0;
            for (int i = 0; i < 3*NUM_PE; i++) begin
                r_s1_sq[i] <= '0;
            end
        end else begin
            r_s1_valid <= w_emit;
            if (w_emit) begin
                r_s1_center <= r_cur;
                for (int i = 0; i < NUM_PE; i++) begin
                    r_s1_sq[i]            <= r_prev_sq[i];
                    r_s1_sq[NUM_PE + i]   <= r_cur_sq[i];
                    r_s1_sq[2*NUM_PE + i] <= w_next_live ? w_in_sq[i] : '0;
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_acc[i] = '0;
            for (int k = 0; k < NTERM; k++) begin
                w_acc[i] = w_acc[i] + ACC_W'(r_s1_sq[NUM_PE + i - RADIUS + k]);
            end
            w_sum[i*OP_WIDTH +: OP_WIDTH] = (w_acc[i] > c_SAT_MAX) ?
                c_SAT_MAX[OP_WIDTH-1:0] : w_acc[i][OP_WIDTH-1:0];
        end
    end

    // Stage 2: saturated sums; outputs hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_square_sum <= '0;
            r_lrn_center <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_square_sum <= w_sum;
                r_lrn_center <= r_s1_center;
            end
        end
    end

    assign bus.square_sum = r_square_sum;
    assign bus.lrn_center = r_lrn_center;
    assign bus.out_valid  = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_lrn_square_sum.sv
`default_nettype none
// ============================================================================
// Module      : tb_lrn_square_sum
// Description : Directed scoreboard bench for lrn_square_sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lrn_square_sum;
    localparam int OPW = 16;
    localparam int NPE = 4;
    localparam int DW  = OPW * NPE;

    typedef struct packed {
        logic [DW-1:0] sum;
        logic [DW-1:0] center;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lrn_square_sum_if #(.OP_WIDTH(OPW), .NUM_PE(NPE), .DATA_WIDTH(DW)) bus ();

    lrn_square_sum #(
        .OP_WIDTH(OPW), .NUM_PE(NPE), .RADIUS(2), .SQ_SHIFT(8), .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;
    int   pushed  = 0;

    // lanes given lowest channel first
    function automatic logic [DW-1:0] w4(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic expect_out(input logic [DW-1:0] sum, input logic [DW-1:0] center);
        exp_t e;
        e.sum    = sum;
        e.center = center;
        q.push_back(e);
        pushed++;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic lst);
        bus.enable  = 1'b1;
        bus.data_in = d;
        bus.last    = lst;
        @(posedge clk);
        #1;
        bus.enable  = 1'b0;
        bus.last    = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d outputs still pending, required 0", name, q.size());
            q.delete();
        end
        idle(2);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            exp_t e;
            strobes++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got sum=%h center=%h, required no output",
                         bus.square_sum, bus.lrn_center);
            end else begin
                e = q.pop_front();
                checks += 2;
                if (bus.square_sum !== e.sum) begin
                    errors++;
                    $display("FAIL square_sum: got %h, required %h", bus.square_sum, e.sum);
                end
                if (bus.lrn_center !== e.center) begin
                    errors++;
                    $display("FAIL lrn_center: got %h, required %h", bus.lrn_center, e.center);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] one, two, maxv, neg, d;
        int snap;
        one  = {4{16'h0100}};
        two  = {4{16'h0200}};
        maxv = {4{16'h7FFF}};
        neg  = {4{16'hFF00}};

        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.last    = 1'b0;
        bus.data_in = '0;
        idle(3);
        reset = 1'b0;
        #1;

        checks += 3;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid);
        end
        if (bus.square_sum !== '0) begin
            errors++; $display("FAIL reset_sum: got %h, required 0", bus.square_sum);
        end
        if (bus.lrn_center !== '0) begin
            errors++; $display("FAIL reset_center: got %h, required 0", bus.lrn_center);
        end

        // single-word group
        expect_out(w4(16'h0300, 16'h0400, 16'h0400, 16'h0300), one);
        send(one, 1'b1);
        drain("single");

        // two-word group
        expect_out(w4(16'h0300, 16'h0400, 16'h0500, 16'h0500), one);
        expect_out(w4(16'h0500, 16'h0500, 16'h0400, 16'h0300), one);
        send(one, 1'b0);
        send(one, 1'b1);
        drain("two_word");

        // back-to-back single-word groups
        expect_out(w4(16'h0300, 16'h0400, 16'h0400, 16'h0300), one);
        expect_out(w4(16'h0C00, 16'h1000, 16'h1000, 16'h0C00), two);
        send(one, 1'b1);
        send(two, 1'b1);
        drain("back_to_back");

        // saturation and negative input
        expect_out(maxv, maxv);
        send(maxv, 1'b1);
        expect_out(w4(16'h0300, 16'h0400, 16'h0400, 16'h0300), neg);
        send(neg, 1'b1);
        drain("sat_neg");

        // a single hot lane exposes lane ordering
        d = w4(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        expect_out(w4(16'h0100, 16'h0100, 16'h0100, 16'h0000), d);
        send(d, 1'b1);
        drain("hot_lane");

        // gapped two-word group
        expect_out(w4(16'h0300, 16'h0400, 16'h0500, 16'h0500), one);
        expect_out(w4(16'h0500, 16'h0500, 16'h0400, 16'h0300), one);
        snap = strobes;
        send(one, 1'b0);
        idle(5);
        checks++;
        if (strobes != snap) begin
            errors++;
            $display("FAIL gap_strobe: got %0d strobes during gap, required 0", strobes - snap);
        end
        send(one, 1'b1);
        drain("gapped");

        // reset discards a held word
        send(two, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        expect_out(w4(16'h0300, 16'h0400, 16'h0400, 16'h0300), one);
        send(one, 1'b1);
        drain("reset_mid");
        idle(5);

        checks++;
        if (strobes != pushed) begin
            errors++;
            $display("FAIL strobe_count: got %0d, required %0d", strobes, pushed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/lrn_square_sum.md
# lrn_square_sum

Local-response-normalization window stage, directly upstream of the normalization block. Takes a stream of NUM_PE-lane activation words (consecutive channels of one pixel), forms per-lane sum of squares over a ±RADIUS channel window confined to the current channel group, and emits the sum together with the unmodified centre value. Outputs connect straight to the normalization stage's `square_sum`, `lrn_center` and `enable`.

## Interface
- OP_WIDTH, 16: signed fixed-point lane width.
- NUM_PE, 4: lanes per word; lane i = bits [i*OP_WIDTH +: OP_WIDTH]; lane 0 = lowest channel.
- RADIUS, 2: window half-width in channels; legal range 1..NUM_PE.
- SQ_SHIFT, 8: arithmetic right shift applied to each square (fraction bits).
- DATA_WIDTH, OP_WIDTH*NUM_PE: word width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  data_in/last valid this cycle; no backpressure.
- data_in  in  DATA_WIDTH  NUM_PE signed channel values.
- last  in  1  qualifies enable; word is final word of its channel group.
- square_sum  out  DATA_WIDTH  per-lane unsigned saturated window sum.
- lrn_center  out  DATA_WIDTH  data_in word the sums belong to, unmodified.
- out_valid  out  1  one-cycle strobe per output word.

## Operation
- Global channel index = word_index_in_group*NUM_PE + lane. Window for channel c: c-RADIUS..c+RADIUS; channels outside current group contribute 0.
- Square: full 2*OP_WIDTH signed product x*x, arithmetic >> SQ_SHIFT, then summed in an accumulator wide enough for 2*RADIUS+1 terms (no overflow); final result saturates to 2^(OP_WIDTH-1)-1.
- Buffers: prev (word before centre), cur (centre), each holding raw value and its squares. Output for cur needs next word, so one word of lookahead.
- FSM:
  - EMPTY: nothing held. enable → cur<=data_in, prev<=0; go PENDING (FLUSH if last).
  - PENDING: cur held, awaiting next. enable → emit(prev,cur,next=data_in); prev<=cur; cur<=data_in; go FLUSH if last, else stay. No enable → hold, no emit.
  - FLUSH: emit(prev,cur,next=0); prev<=0. Same-cycle enable → cur<=data_in as first word of new group (prev=0), go PENDING (FLUSH if last); else go EMPTY.
- Groups never leak: prev cleared at group start, next forced 0 at group end.
- Single-word group (enable&last from EMPTY) handled as EMPTY→FLUSH with prev=next=0.
- `last` ignored when enable=0.

## Timing
- Reset: square_sum=0, lrn_center=0, out_valid=0, state EMPTY, prev/cur cleared. Reset mid-group discards held words; no output from them afterwards.
- Emit event at clock edge T (state/inputs sampled at T). Stage 1 registers window squares and centre at T; stage 2 registers summed/saturated outputs at T+1; out_valid high for exactly the cycle following edge T+1. Latency from the trigger edge: 2 cycles.
- Throughput: one output per cycle sustained; back-to-back groups with enable every cycle incur no bubble and no dropped word.
- out_valid count equals accepted-word count (after flush completes).
- Outputs hold last values when out_valid=0.

## Test plan
- Single-word group, all lanes 0x0100 (1.0), last=1 → one strobe 2 cycles later, square_sum lanes[0..3] = 0x0300,0x0400,0x0400,0x0300; lrn_center = input.
- Two-word group all 0x0100 (last on word 2) → word1 sums 0x0300,0x0400,0x0500,0x0500; word2 sums 0x0500,0x0500,0x0400,0x0300; two strobes.
- Back-to-back single-word groups on consecutive cycles, A=all 0x0100, B=all 0x0200 → A gives 0x0300,0x0400,0x0400,0x0300; B gives 0x0C00,0x1000,0x1000,0x0C00 (no cross-group contribution), strobes on consecutive cycles.
- Saturation/sign: single-word group all 0x7FFF → all lanes 0x7FFF; all 0xFF00 (-1.0) → 0x0300,0x0400,0x0400,0x0300.
- Gapped input: word1 of a 2-word group, 5 idle cycles, word2 with last → no strobe during gap; outputs match scenario 2.
- Reset mid-group: accept one non-last word, assert reset 1 cycle, then single-word group all 0x0100 → exactly one strobe, values as scenario 1.
